// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM port-B stream reader.
package bram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Below this depth the read credit loop cannot sustain one beat per cycle.
  localparam int FIFO_DEPTH_MIN = 3;

endpackage

// File: rtl/rd_skid_fifo.sv
// Show-ahead synchronous FIFO that absorbs BRAM read data ahead of the stream port.
// DEPTH must be a power of two so the pointers wrap naturally.
module rd_skid_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and a resettable array would cost a reset mux per bit.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  // Zero while empty so the stream bus reads clean when nothing is offered.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// Burst reader for BRAM port B: issues LEN reads from BASE_ADDR and streams them out.
// Optional macro READ_STRIDE_EN adds a stride port; otherwise the address steps by 1.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
`ifdef READ_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_e             r_state;
  rd_state_e             w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic                  r_pending;
  logic                  r_pend_last;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] w_step;

  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_occ;
  logic                  w_empty;
  logic [DATA_WIDTH:0]   w_fifo_out;
  logic                  w_issue;
  logic                  w_last_issue;
  logic                  w_pop;

`ifdef READ_STRIDE_EN
  logic [ADDR_WIDTH-1:0] r_stride;

  always_ff @(posedge clk) begin
    if (rst)                          r_stride <= '0;
    else if (r_state == IDLE && start) r_stride <= stride;
  end

  assign w_step = r_stride;
`else
  assign w_step = ADDR_WIDTH'(1);
`endif

  // Credit: an in-flight read plus stored beats may never exceed the FIFO.
  assign w_occ        = w_count + CW'(r_pending);
  assign w_issue      = (r_state == READ) && (w_occ < CW'(FIFO_DEPTH));
  assign w_last_issue = w_issue && (r_issued == r_len - LEN_WIDTH'(1));
  assign w_pop        = !w_empty && m_ready;

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (len == '0) ? DONE : READ;
      READ:    if (w_last_issue) w_next = DRAIN;
      DRAIN:   if (w_pop && w_fifo_out[DATA_WIDTH]) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_pending   <= 1'b0;
      r_pend_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_done      <= (r_state == DONE);
      r_pending   <= w_issue;
      r_pend_last <= w_last_issue;
      if (r_state == IDLE && start) begin
        r_addr   <= base_addr;
        r_len    <= len;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= r_addr + w_step;
        r_issued <= r_issued + LEN_WIDTH'(1);
      end
    end
  end

  // doutb is valid exactly one cycle after enb, so r_pending doubles as push.
  rd_skid_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pending),
    .i_data  ({r_pend_last, doutb}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign enb     = w_issue;
  assign addrb   = r_addr;
  assign m_valid = !w_empty;
  assign m_data  = w_fifo_out[DATA_WIDTH-1:0];
  assign m_last  = w_fifo_out[DATA_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with an inline dual-port BRAM model (port A preload).
// Define READ_STRIDE_EN for both RTL and bench to exercise the stride cases.
module tb_bram_stream_reader;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int LW = 10;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
`ifdef READ_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy, done, enb, m_valid, m_ready, m_last;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] m_data;

  // Memory model: port A write for preload, port B registered read.
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] mem [1 << AW];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    if (enb) doutb <= mem[addrb];
  end

  bram_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef READ_STRIDE_EN
    .stride    (stride),
`endif
    .busy      (busy),
    .done      (done),
    .enb       (enb),
    .addrb     (addrb),
    .doutb     (doutb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int enb_cnt = 0, valid_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int first_enb = -1, first_valid = -1, done_cyc = -1, last_hs_cyc = -1;
  bit          stall_prev = 1'b0;
  logic [DW:0] stall_word = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations on every handshake/issue.
  initial begin
    logic [DW:0]   e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'({m_last, m_data}), 32'(stall_word));
      end
      stall_prev = m_valid && !m_ready;
      stall_word = {m_last, m_data};
      if (m_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc_cnt;
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (m_last) last_hs_cyc = cyc_cnt;
        if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("beat", 32'({m_last, m_data}), 32'(e));
        end
      end
      if (enb) begin
        enb_cnt++;
        if (first_enb < 0) first_enb = cyc_cnt;
        if (exp_addr_q.size() == 0) check("extra_enb", 32'd1, 32'd0);
        else begin
          a = exp_addr_q.pop_front();
          check("addr", 32'(addrb), 32'(a));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
    end
  end

  function automatic logic ready_at(input int mode, input int c);
    case (mode)
      1:       return (c % 2 == 0);
      2:       return (c >= 20);
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_stats();
    enb_cnt = 0; valid_cnt = 0; hs_cnt = 0; done_cnt = 0;
    first_enb = -1; first_valid = -1; done_cyc = -1; last_hs_cyc = -1;
  endtask

  task automatic push_expect(input int base, input int n, input int stp);
    for (int i = 0; i < n; i++) begin
      int adr;
      adr = (base + i * stp) % (1 << AW);
      exp_addr_q.push_back(AW'(adr));
      exp_q.push_back({(i == n - 1), DW'(adr + 100)});
    end
  endtask

  // mode 0: ready high; 1: ready toggles 1010...; 2: ready low for 20 cycles then high.
  task automatic run_burst(input int base, input int n, input int mode, input int stp);
    int start_cyc;
    int c;
    clear_stats();
    push_expect(base, n, stp);
    base_addr = AW'(base);
    len       = LW'(n);
`ifdef READ_STRIDE_EN
    stride    = AW'(stp);
`endif
    start     = 1'b1;
    m_ready   = ready_at(mode, 0);
    start_cyc = cyc_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (done_cnt == 0 && c < 400) begin
      if (mode == 2 && c == 19) begin
        check("stall_enb_le_depth", 32'(enb_cnt <= FD), 32'd1);
        check("stall_valid", 32'(m_valid), 32'd1);
      end
      m_ready = ready_at(mode, c + 1);
      @(posedge clk); #1;
      c++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("enb_count", 32'(enb_cnt), 32'(n));
    check("beat_count", 32'(hs_cnt), 32'(n));
    check("exp_left", 32'(exp_q.size()), 32'd0);
    check("addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    if (n == 0) begin
      check("len0_done_lat", 32'(done_cyc - start_cyc), 32'd2);
      check("len0_no_valid", 32'(valid_cnt), 32'd0);
    end else begin
      check("done_after_last", 32'((done_cyc - last_hs_cyc) >= 1 && (done_cyc - last_hs_cyc) <= 2), 32'd1);
      if (mode == 0) begin
        check("enb_latency", 32'(first_enb - start_cyc), 32'd1);
        check("valid_latency", 32'(first_valid - start_cyc), 32'd3);
        check("no_bubbles", 32'(last_hs_cyc - first_valid), 32'(n - 1));
      end
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    int c;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; len = '0;
`ifdef READ_STRIDE_EN
    stride = '0;
`endif
    wea = 1'b0; addra = '0; dina = '0;
    @(posedge clk); #1;
    for (int i = 0; i < (1 << AW); i++) begin
      wea = 1'b1; addra = AW'(i); dina = DW'(i + 100);
      @(posedge clk); #1;
    end
    wea = 1'b0;
    check("reset_outputs", 32'({busy, done, enb, m_valid, m_last, addrb, m_data}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_burst(10, 5, 0, 1);
    run_burst(10, 5, 1, 1);
    run_burst(10, 5, 2, 1);
    run_burst(510, 4, 0, 1);
    run_burst(0, 0, 0, 1);

    // Abort mid-burst after two beats, then confirm a clean restart.
    clear_stats();
    push_expect(10, 5, 1);
    base_addr = AW'(10); len = LW'(5); start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (hs_cnt < 2 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("pre_rst_beats", 32'(hs_cnt >= 2), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({busy, done, enb, m_valid, m_last, addrb, m_data}), 32'd0);
    @(posedge clk); #1;
    exp_q.delete();
    exp_addr_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    run_burst(20, 3, 0, 1);

`ifdef READ_STRIDE_EN
    run_burst(0, 4, 0, 3);
    run_burst(0, 4, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
